// File: rtl/cascade_cache_reader.sv
// Streams a contiguous range of cascade cache words out as valid/ready data.
// Reads are issued only while the return buffer has room, so a stalled consumer never loses a word.
module cascade_cache_reader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned WORD_SIZE  = 64,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [WORD_SIZE-1:0]  rdata,
  output logic [WORD_SIZE-1:0]  data_out,
  output logic                  data_valid,
  input  logic                  data_ready
);

  localparam int unsigned CW  = ADDR_WIDTH + 1;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < RD_LATENCY + 2) begin : g_depth_check
    $error("FIFO_DEPTH must be at least RD_LATENCY+2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         issued_q;
  logic [CW-1:0]         acc_q;
  logic [RD_LATENCY-1:0] vsr;

  logic [WORD_SIZE-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [FCW-1:0]        cnt;

  logic                  pop_c;
  logic                  push_c;
  logic [CW-1:0]         acc_next_c;
  logic [CW-1:0]         outstanding_c;
  logic                  credit_ok_c;
  logic [FCW-1:0]        cnt_next_c;
  logic [FCW-1:0]        remain_c;
  logic [PW-1:0]         rd_next_c;
  logic [WORD_SIZE-1:0]  head_next_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Outstanding words (issued but not yet accepted) never exceed the buffer size.
  always_comb begin
    pop_c         = data_valid & data_ready;
    push_c        = vsr[RD_LATENCY-1];
    acc_next_c    = acc_q + CW'(pop_c);
    outstanding_c = issued_q - acc_next_c;
    credit_ok_c   = (outstanding_c < CW'(FIFO_DEPTH));
    cnt_next_c    = cnt + FCW'(push_c) - FCW'(pop_c);
    remain_c      = cnt - FCW'(pop_c);
    rd_next_c     = pop_c ? ptr_inc(rd_ptr) : rd_ptr;
    head_next_c   = (remain_c == '0) ? rdata : mem[rd_next_c];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      re       <= 1'b0;
      raddr    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      acc_q    <= '0;
    end else begin
      done  <= 1'b0;
      re    <= 1'b0;
      acc_q <= acc_next_c;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= length;
            acc_q  <= '0;
            if (length == '0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              issued_q <= '0;
            end else begin
              state    <= S_ISSUE;
              busy     <= 1'b1;
              re       <= 1'b1;
              raddr    <= base_addr;
              issued_q <= CW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (issued_q == len_q) begin
            state <= S_DRAIN;
          end else if (credit_ok_c) begin
            re       <= 1'b1;
            raddr    <= base_q + issued_q[ADDR_WIDTH-1:0];
            issued_q <= issued_q + CW'(1);
          end
        end
        S_DRAIN: begin
          if (acc_next_c == len_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency tracker: each re emerges RD_LATENCY cycles later as a buffer write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vsr <= '0;
    end else begin
      vsr[0] <= re;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        vsr[i] <= vsr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= rdata;
    end
  end

  // Return buffer with a registered head: data_out/data_valid are loaded from the next-cycle head.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr     <= rd_next_c;
      cnt        <= cnt_next_c;
      data_valid <= (cnt_next_c != '0);
      if (cnt_next_c != '0) begin
        data_out <= head_next_c;
      end
    end
  end

  always @(posedge clk) begin
    if (resetn) begin
      assert (!(push_c && !pop_c && cnt == FCW'(FIFO_DEPTH)));
    end
  end

endmodule

// File: tb/tb_cascade_cache_reader.sv
// Randomized scoreboard bench for cascade_cache_reader against a flat memory model.
module tb_cascade_cache_reader;

  localparam int unsigned AW  = 10;
  localparam int unsigned WS  = 64;
  localparam int unsigned NW  = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, re;
  logic [AW-1:0] raddr;
  logic [WS-1:0] rdata;
  logic [WS-1:0] data_out;
  logic          data_valid;
  logic          data_ready;

  cascade_cache_reader #(
    .ADDR_WIDTH(AW), .WORD_SIZE(WS), .RD_LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .re(re), .raddr(raddr), .rdata(rdata),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [WS-1:0] mem [NW];
  logic [WS-1:0] exp_data [$];
  logic [AW-1:0] exp_addr [$];

  int            ready_mode = 0;
  int            re_cnt, dv_cnt, done_cnt, first_re, first_dv, done_cyc, start_cyc;
  bit            busy_seen;
  bit            prev_stall = 1'b0;
  logic [WS-1:0] prev_data;

  task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Cache model: fixed two-cycle read latency, junk on rdata when no read returns.
  logic          p_re = 1'b0;
  logic [AW-1:0] p_addr = '0;
  always @(posedge clk) begin
    p_re   <= re;
    p_addr <= raddr;
    rdata  <= p_re ? mem[p_addr] : {$urandom, $urandom};
  end

  initial begin
    data_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      data_ready = (ready_mode == 0) ? 1'b1 :
                   (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares issued addresses and accepted words against the scoreboard queues.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (re) begin
        re_cnt++;
        if (first_re < 0) first_re = cyc;
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_re: raddr %0h with no read expected", raddr);
        end else begin
          chk("raddr", WS'(raddr), WS'(exp_addr.pop_front()));
        end
      end
      if (data_valid) begin
        dv_cnt++;
        if (first_dv < 0) first_dv = cyc;
      end
      if (prev_stall) begin
        chk("hold_valid", WS'(data_valid), WS'(1));
        chk("hold_data", data_out, prev_data);
      end
      if (data_valid && data_ready) begin
        if (exp_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_data: %0h with no word expected", data_out);
        end else begin
          chk("data", data_out, exp_data.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen = 1'b1;
      prev_stall = data_valid && !data_ready;
      prev_data  = data_out;
    end
  end

  task automatic clear_stats();
    re_cnt = 0; dv_cnt = 0; first_re = -1; first_dv = -1; done_cyc = -1; busy_seen = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l, input bit expect_it);
    logic [AW-1:0] a;
    start = 1'b1; base_addr = b; length = l;
    if (expect_it) begin
      start_cyc = cyc;
      for (int i = 0; i < int'(l); i++) begin
        a = b + AW'(i);
        exp_addr.push_back(a);
        exp_data.push_back(mem[a]);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(posedge clk); n++;
    end
    #1;
    chk("done_seen", WS'(done_cnt != d0), WS'(1));
  endtask

  initial begin
    int d0;
    for (int i = 0; i < int'(NW); i++) mem[i] = {$urandom, $urandom};
    resetn = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    clear_stats(); done_cnt = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", WS'(busy), 0);
    chk("rst_done", WS'(done), 0);
    chk("rst_re", WS'(re), 0);
    chk("rst_raddr", WS'(raddr), 0);
    chk("rst_valid", WS'(data_valid), 0);
    chk("rst_data", data_out, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Basic four-word read with full-rate consumer.
    clear_stats(); d0 = done_cnt;
    do_start(10'h010, 11'd4, 1'b1);
    wait_done(d0, 50);
    chk("t1_first_re", WS'(first_re - start_cyc), 1);
    chk("t1_re_cnt", WS'(re_cnt), 4);
    chk("t1_first_valid", WS'(first_dv - start_cyc), 4);
    chk("t1_done_cycle", WS'(done_cyc - start_cyc), 8);
    repeat (2) @(posedge clk); #1;

    // Consumer stalled: only buffer-depth reads may be issued.
    ready_mode = 1; @(posedge clk); #1;
    clear_stats(); d0 = done_cnt;
    do_start(10'h0A0, 11'd8, 1'b1);
    repeat (20) @(posedge clk); #1;
    chk("t2_re_stalled", WS'(re_cnt), 4);
    chk("t2_valid_held", WS'(data_valid), 1);
    chk("t2_head", data_out, (exp_data.size() != 0) ? exp_data[0] : '0);
    ready_mode = 0;
    wait_done(d0, 100);
    chk("t2_re_total", WS'(re_cnt), 8);
    repeat (2) @(posedge clk); #1;

    // Address wrap.
    clear_stats(); d0 = done_cnt;
    do_start(10'h3FE, 11'd4, 1'b1);
    wait_done(d0, 50);
    chk("t3_re_cnt", WS'(re_cnt), 4);
    repeat (2) @(posedge clk); #1;

    // Zero length.
    clear_stats(); d0 = done_cnt;
    do_start(10'h055, 11'd0, 1'b1);
    wait_done(d0, 10);
    chk("t4_done_cycle", WS'(done_cyc - start_cyc), 1);
    chk("t4_no_re", WS'(re_cnt), 0);
    chk("t4_no_busy", WS'(busy_seen), 0);
    repeat (2) @(posedge clk); #1;

    // Second start while busy is ignored.
    clear_stats(); d0 = done_cnt;
    do_start(10'h020, 11'd6, 1'b1);
    @(posedge clk); #1;
    do_start(10'h100, 11'd3, 1'b0);
    wait_done(d0, 60);
    repeat (10) @(posedge clk); #1;
    chk("t5_one_done", WS'(done_cnt - d0), 1);
    chk("t5_re_cnt", WS'(re_cnt), 6);

    // Reset in the middle of draining.
    clear_stats(); d0 = done_cnt;
    do_start(10'h200, 11'd4, 1'b1);
    repeat (4) @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    exp_addr.delete(); exp_data.delete();
    chk("t6_busy", WS'(busy), 0);
    chk("t6_re", WS'(re), 0);
    chk("t6_raddr", WS'(raddr), 0);
    chk("t6_valid", WS'(data_valid), 0);
    chk("t6_data", data_out, 0);
    repeat (2) @(posedge clk); #1;
    resetn = 1'b1;
    clear_stats();
    repeat (6) @(posedge clk); #1;
    chk("t6_stale_valid", WS'(dv_cnt), 0);
    chk("t6_no_done", WS'(done_cnt - d0), 0);
    d0 = done_cnt;
    do_start(10'h300, 11'd5, 1'b1);
    wait_done(d0, 60);
    repeat (2) @(posedge clk); #1;

    // Random transfers with a randomly stalling consumer.
    ready_mode = 2;
    for (int k = 0; k < 6; k++) begin
      d0 = done_cnt;
      do_start(AW'($urandom), (AW+1)'($urandom_range(1, 40)), 1'b1);
      wait_done(d0, 500);
      repeat (2) @(posedge clk); #1;
    end
    d0 = done_cnt;
    do_start(AW'($urandom), 11'd1024, 1'b1);
    wait_done(d0, 20000);
    repeat (4) @(posedge clk); #1;

    chk("end_addr_queue", WS'(exp_addr.size()), 0);
    chk("end_data_queue", WS'(exp_data.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
